param_bank: RTL and testbench
=============================

PARAM_BANK -- requirements
Module: param_bank

Interface
REQ-001 Parameter NREG, default 16, number of 32-bit parameter slots (2..64).
REQ-002 Parameter COMMIT_MODE, default 1: 0 = writes take effect immediately; 1 = writes are shadowed until commit_tick.
REQ-003 Parameter DEFAULTS, NREG*32 bits, default all-zero, slot k reset value in bits [32k+31:32k].
REQ-004 Port clk input 1: sole clock, rising edge; all logic is synchronous to it.
REQ-005 Port reset input 1: synchronous, active-high.
REQ-006 Port wr_trig input NREG: single-cycle write strobes, bit k targets slot k.
REQ-007 Port wr_lo input 16: low half-word of write data.
REQ-008 Port wr_hi input 16: high half-word of write data.
REQ-009 Port commit_tick input 1: single-cycle pulse, simulation-step boundary.
REQ-010 Port restore_defaults input 1: single-cycle pulse, reloads DEFAULTS.
REQ-011 Port rd_sel input clog2(NREG): readback slot select.
REQ-012 Port rd_data output 32: registered active value of slot rd_sel.
REQ-013 Port params_out output NREG*32: active values of all slots, slot k in [32k+31:32k].
REQ-014 Port pending output NREG: slot holds a shadow value not yet committed.
REQ-015 Port commit_cnt output 16: number of effective commits, saturating.
REQ-016 Port err_multi output 1: sticky flag, set when more than one wr_trig bit is high in one cycle.

Function
REQ-017 Write: on a cycle with wr_trig[k]=1, shadow[k] SHALL load {wr_hi, wr_lo}.
REQ-018 Multiple wr_trig bits in one cycle: every selected slot loads the same data, and err_multi is set on the next edge.
REQ-019 COMMIT_MODE=1: a write sets pending[k]; active[k] is unchanged until commit.
REQ-020 COMMIT_MODE=1: on commit_tick, every slot with pending=1 copies shadow to active and clears pending, all on the same edge.
REQ-021 Write and commit_tick in the same cycle on slot k: the commit uses the pre-write shadow; the new value lands in shadow; pending[k] ends at 1.
REQ-022 COMMIT_MODE=0: a write updates shadow and active on the same edge; pending stays 0; commit_tick is ignored.
REQ-023 Latency: params_out reflects a write (mode 0) or a commit (mode 1) one cycle after the strobe.
REQ-024 commit_cnt increments by 1 on each commit_tick with at least one pending bit, and saturates at 0xFFFF.
REQ-025 commit_tick with no pending bits: no state change, and commit_cnt holds.
REQ-026 restore_defaults: shadow and active both load DEFAULTS and pending clears; commit_cnt and err_multi hold.
REQ-027 restore_defaults has priority over same-cycle writes and commit_tick, which are discarded.
REQ-028 rd_data = active[rd_sel], registered with 1-cycle latency; rd_sel >= NREG reads 0.
REQ-029 There is no state machine; each slot is a two-stage register (shadow and active) with pending flag.

Reset
REQ-030 Reset SHALL set shadow and active to DEFAULTS, pending to 0, commit_cnt to 0, err_multi to 0, and rd_data to 0.
REQ-031 Reset has priority over every other input; writes or ticks in the reset cycle are discarded.
REQ-032 Reset asserted mid-operation discards all uncommitted shadow values.

Structure
REQ-033 Package param_bank_pkg SHALL hold the data width (32) and named default constants: F_GAMMA_80=0x42A00000, F_PPS_COEF=0x3F666666, BDAMP_1=0x3E714120, BDAMP_2=0x3D144674, BDAMP_CHAIN=0x3C5844D0.
REQ-034 Sub-module param_bank_slot SHALL implement one shadow/active/pending slot and be instantiated NREG times by generate.
REQ-035 Readback mux, commit counter and err_multi live in the top of param_bank.

Verification
REQ-036 Reset with slot 4 default 0x42A00000 -> params_out[4] = 0x42A00000, pending = 0, commit_cnt = 0, rd_data = 0.
REQ-037 Mode 1: wr_trig[2] with hi=0x3F80, lo=0x0000 -> pending[2]=1 and active unchanged; next commit_tick -> active[2]=0x3F800000, pending[2]=0, commit_cnt=1.
REQ-038 Mode 1: write 0x11112222 to slot 3, then write 0x33334444 to slot 3 in the same cycle as commit_tick -> active[3]=0x11112222, shadow[3]=0x33334444, pending[3]=1.
REQ-039 wr_trig=0x0003 with data 0xDEADBEEF -> slots 0 and 1 both hold 0xDEADBEEF; err_multi=1 and stays 1 until reset.
REQ-040 Issue 65,540 commit_ticks, each preceded by a write -> commit_cnt = 0xFFFF; restore_defaults during this run -> all slots at DEFAULTS, commit_cnt held.
REQ-041 Mode 0: wr_trig[5] with 0x00000008 -> params_out[5]=0x00000008 the next cycle; rd_sel=5 -> rd_data=0x00000008 one cycle later; rd_sel=NREG -> rd_data=0.

Source files
------------

// File: rtl/param_bank_pkg.sv
// Shared constants and helpers for the parameter bank.
// Holds the slot width, the named float default constants and a multi-hot detector.
package param_bank_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] F_GAMMA_80  = 32'h42A0_0000;
    localparam logic [DATA_W-1:0] F_PPS_COEF  = 32'h3F66_6666;
    localparam logic [DATA_W-1:0] BDAMP_1     = 32'h3E71_4120;
    localparam logic [DATA_W-1:0] BDAMP_2     = 32'h3D14_4674;
    localparam logic [DATA_W-1:0] BDAMP_CHAIN = 32'h3C58_44D0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // True when more than one bit of v is set (clearing the lowest set bit leaves something).
    function automatic logic multi_hot(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/param_bank_slot.sv
// One parameter slot: shadow register, active register and pending flag.
// In commit mode writes land in shadow and are promoted on a commit pulse.
module param_bank_slot
    import param_bank_pkg::*;
#(
    parameter int                COMMIT_MODE = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              restore,
    output logic [DATA_W-1:0] active,
    output logic              pending
);

    logic [DATA_W-1:0] shadow_r;
    logic [DATA_W-1:0] active_r;
    logic              pending_r;

    // Slot state update; a commit reads the shadow value from before a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset || restore) begin
            shadow_r  <= RESET_VAL;
            active_r  <= RESET_VAL;
            pending_r <= 1'b0;
        end else if (COMMIT_MODE == 0) begin
            if (wr_en) begin
                shadow_r <= wr_data;
                active_r <= wr_data;
            end
            pending_r <= 1'b0;
        end else begin
            if (commit && pending_r) begin
                active_r <= shadow_r;
            end
            if (wr_en) begin
                shadow_r  <= wr_data;
                pending_r <= 1'b1;
            end else if (commit) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign active  = active_r;
    assign pending = pending_r;

endmodule

// File: rtl/param_bank.sv
// Bank of NREG shadowed 32-bit parameters with commit counting,
// multi-write error flag and registered readback.
module param_bank
    import param_bank_pkg::*;
#(
    parameter int                       NREG        = 16,
    parameter int                       COMMIT_MODE = 1,
    parameter logic [NREG*DATA_W-1:0]   DEFAULTS    = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREG-1:0]          wr_trig,
    input  logic [15:0]              wr_lo,
    input  logic [15:0]              wr_hi,
    input  logic                     commit_tick,
    input  logic                     restore_defaults,
    input  logic [$clog2(NREG)-1:0]  rd_sel,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NREG*DATA_W-1:0]   params_out,
    output logic [NREG-1:0]          pending,
    output logic [15:0]              commit_cnt,
    output logic                     err_multi
);

    localparam int RD_W = $clog2(NREG);

    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] active_s [NREG];
    logic [NREG-1:0]   pending_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              commit_eff_s;
    logic              multi_s;
    logic [DATA_W-1:0] rd_data_r;
    logic [15:0]       commit_cnt_r;
    logic              err_multi_r;

    assign wr_data_s = {wr_hi, wr_lo};

    for (genvar k = 0; k < NREG; k++) begin : g_slot
        param_bank_slot #(
            .COMMIT_MODE (COMMIT_MODE),
            .RESET_VAL   (DEFAULTS[k*DATA_W +: DATA_W])
        ) u_slot (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_trig[k]),
            .wr_data (wr_data_s),
            .commit  (commit_tick),
            .restore (restore_defaults),
            .active  (active_s[k]),
            .pending (pending_s[k])
        );
        assign params_out[k*DATA_W +: DATA_W] = active_s[k];
    end

    assign pending = pending_s;

    // Commit counts only when it actually promotes something and is not overridden by a restore.
    always_comb begin
        commit_eff_s = 1'b0;
        multi_s      = 1'b0;
        if ((COMMIT_MODE != 0) && commit_tick && !restore_defaults && (|pending_s)) begin
            commit_eff_s = 1'b1;
        end else begin
            commit_eff_s = 1'b0;
        end
        if (!restore_defaults) begin
            multi_s = multi_hot(64'(wr_trig));
        end else begin
            multi_s = 1'b0;
        end
    end

    // Readback select; unmatched (out of range) selects read zero.
    always_comb begin
        rd_word_s = '0;
        for (int k = 0; k < NREG; k++) begin
            rd_word_s = rd_word_s | (active_s[k] & {DATA_W{rd_sel == RD_W'(k)}});
        end
    end

    // Registered readback, saturating commit counter and sticky multi-write flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r    <= '0;
            commit_cnt_r <= 16'd0;
            err_multi_r  <= 1'b0;
        end else begin
            rd_data_r <= rd_word_s;
            if (commit_eff_s && (commit_cnt_r != CNT_MAX)) begin
                commit_cnt_r <= commit_cnt_r + 16'd1;
            end
            if (multi_s) begin
                err_multi_r <= 1'b1;
            end
        end
    end

    assign rd_data    = rd_data_r;
    assign commit_cnt = commit_cnt_r;
    assign err_multi  = err_multi_r;

endmodule

// File: tb/tb_param_bank.sv
// Scoreboard bench for param_bank: a commit-mode bank (NREG=16, named defaults)
// and an immediate-mode bank (NREG=12) driven with directed vectors.
module tb_param_bank;

    localparam int NA = 16;
    localparam int NB = 12;
    localparam logic [NA*32-1:0] DEF_A = {{11{32'h0000_0000}}, 32'h42A0_0000, 32'h3C58_44D0,
                                          32'h3D14_4674, 32'h3E71_4120, 32'h3F66_6666};

    localparam int K_PARAM = 0;
    localparam int K_PEND  = 1;
    localparam int K_CNT   = 2;
    localparam int K_ERR   = 3;
    localparam int K_RD    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [NA-1:0]    a_wr_trig = '0;
    logic [15:0]      a_wr_lo = 16'd0, a_wr_hi = 16'd0;
    logic             a_commit = 1'b0, a_restore = 1'b0;
    logic [3:0]       a_rd_sel = 4'd0;
    logic [31:0]      a_rd_data;
    logic [NA*32-1:0] a_params;
    logic [NA-1:0]    a_pending;
    logic [15:0]      a_cnt;
    logic             a_err;

    logic [NB-1:0]    b_wr_trig = '0;
    logic [15:0]      b_wr_lo = 16'd0, b_wr_hi = 16'd0;
    logic             b_commit = 1'b0, b_restore = 1'b0;
    logic [3:0]       b_rd_sel = 4'd0;
    logic [31:0]      b_rd_data;
    logic [NB*32-1:0] b_params;
    logic [NB-1:0]    b_pending;
    logic [15:0]      b_cnt;
    logic             b_err;

    param_bank #(.NREG(NA), .COMMIT_MODE(1), .DEFAULTS(DEF_A)) dut_a (
        .clk(clk), .reset(reset), .wr_trig(a_wr_trig), .wr_lo(a_wr_lo), .wr_hi(a_wr_hi),
        .commit_tick(a_commit), .restore_defaults(a_restore), .rd_sel(a_rd_sel),
        .rd_data(a_rd_data), .params_out(a_params), .pending(a_pending),
        .commit_cnt(a_cnt), .err_multi(a_err));

    param_bank #(.NREG(NB), .COMMIT_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .wr_trig(b_wr_trig), .wr_lo(b_wr_lo), .wr_hi(b_wr_hi),
        .commit_tick(b_commit), .restore_defaults(b_restore), .rd_sel(b_rd_sel),
        .rd_data(b_rd_data), .params_out(b_params), .pending(b_pending),
        .commit_cnt(b_cnt), .err_multi(b_err));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          dut;
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int dut, input int kind, input int idx);
        case (kind)
            K_PARAM: return (dut == 0) ? a_params[idx*32 +: 32] : b_params[idx*32 +: 32];
            K_PEND:  return (dut == 0) ? 32'(a_pending) : 32'(b_pending);
            K_CNT:   return (dut == 0) ? 32'(a_cnt) : 32'(b_cnt);
            K_ERR:   return (dut == 0) ? 32'(a_err) : 32'(b_err);
            K_RD:    return (dut == 0) ? a_rd_data : b_rd_data;
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic push_exp(input int dut, input int kind, input int idx,
                            input logic [31:0] v, input string name);
        exp_t e;
        e.due = cyc; e.dut = dut; e.kind = kind; e.idx = idx; e.exp = v; e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: on each falling edge, retire every expectation due for this cycle.
    always @(negedge clk) begin : monitor
        logic [31:0] got;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                got = actual(sbq[i].dut, sbq[i].kind, sbq[i].idx);
                vectors++;
                if (got !== sbq[i].exp || sbq[i].due != cyc) begin
                    miscompares++;
                    $display("FAIL %s (dut %0d idx %0d cyc %0d): got %08h, want %08h",
                             sbq[i].name, sbq[i].dut, sbq[i].idx, cyc, got, sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [NA-1:0] trig, input logic [31:0] d,
                           input logic c, input logic r);
        a_wr_trig = trig; a_wr_hi = d[31:16]; a_wr_lo = d[15:0];
        a_commit = c; a_restore = r;
        step();
        a_wr_trig = '0; a_commit = 1'b0; a_restore = 1'b0;
    endtask

    task automatic pulse_b(input logic [NB-1:0] trig, input logic [31:0] d, input logic c);
        b_wr_trig = trig; b_wr_hi = d[31:16]; b_wr_lo = d[15:0]; b_commit = c;
        step();
        b_wr_trig = '0; b_commit = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a write and tick in the reset cycle that must be discarded.
        step();
        pulse_a(16'h0040, 32'h1234_5678, 1'b1, 1'b0);
        reset = 1'b0;
        push_exp(0, K_PARAM, 4, 32'h42A0_0000, "reset_slot4");
        push_exp(0, K_PARAM, 0, 32'h3F66_6666, "reset_slot0");
        push_exp(0, K_PARAM, 6, 32'h0000_0000, "reset_discard_write");
        push_exp(0, K_PEND,  0, 32'h0000_0000, "reset_pending");
        push_exp(0, K_CNT,   0, 32'h0000_0000, "reset_cnt");
        push_exp(0, K_ERR,   0, 32'h0000_0000, "reset_err");
        push_exp(0, K_RD,    0, 32'h0000_0000, "reset_rd");
        push_exp(1, K_PARAM, 5, 32'h0000_0000, "b_reset_slot5");
        push_exp(1, K_RD,    0, 32'h0000_0000, "b_reset_rd");

        // Shadowed write then commit.
        pulse_a(16'h0004, 32'h3F80_0000, 1'b0, 1'b0);
        push_exp(0, K_PEND,  0, 32'h0000_0004, "wr2_pending");
        push_exp(0, K_PARAM, 2, 32'h3D14_4674, "wr2_active_held");
        pulse_a(16'h0000, 32'h0000_0000, 1'b1, 1'b0);
        push_exp(0, K_PARAM, 2, 32'h3F80_0000, "commit2_active");
        push_exp(0, K_PEND,  0, 32'h0000_0000, "commit2_pending");
        push_exp(0, K_CNT,   0, 32'h0000_0001, "commit2_cnt");

        // Tick with nothing pending.
        pulse_a(16'h0000, 32'h0000_0000, 1'b1, 1'b0);
        push_exp(0, K_CNT,   0, 32'h0000_0001, "idle_tick_cnt");

        // Write colliding with commit on slot 3.
        pulse_a(16'h0008, 32'h1111_2222, 1'b0, 1'b0);
        push_exp(0, K_PEND,  0, 32'h0000_0008, "wr3_pending");
        pulse_a(16'h0008, 32'h3333_4444, 1'b1, 1'b0);
        push_exp(0, K_PARAM, 3, 32'h1111_2222, "collide_active");
        push_exp(0, K_PEND,  0, 32'h0000_0008, "collide_pending");
        push_exp(0, K_CNT,   0, 32'h0000_0002, "collide_cnt");
        pulse_a(16'h0000, 32'h0000_0000, 1'b1, 1'b0);
        push_exp(0, K_PARAM, 3, 32'h3333_4444, "collide_shadow_commit");
        push_exp(0, K_CNT,   0, 32'h0000_0003, "collide_cnt2");

        // Readback.
        a_rd_sel = 4'd3; step();
        push_exp(0, K_RD, 0, 32'h3333_4444, "rd_slot3");
        a_rd_sel = 4'd4; step();
        push_exp(0, K_RD, 0, 32'h42A0_0000, "rd_slot4");

        // Multi-hot write.
        pulse_a(16'h0003, 32'hDEAD_BEEF, 1'b0, 1'b0);
        push_exp(0, K_ERR,   0, 32'h0000_0001, "multi_err");
        push_exp(0, K_PEND,  0, 32'h0000_0003, "multi_pending");
        pulse_a(16'h0000, 32'h0000_0000, 1'b1, 1'b0);
        push_exp(0, K_PARAM, 0, 32'hDEAD_BEEF, "multi_slot0");
        push_exp(0, K_PARAM, 1, 32'hDEAD_BEEF, "multi_slot1");
        push_exp(0, K_CNT,   0, 32'h0000_0004, "multi_cnt");
        step(); step();
        push_exp(0, K_ERR,   0, 32'h0000_0001, "multi_err_sticky");

        // Restore beats same-cycle write and commit.
        pulse_a(16'h0080, 32'h7777_0000, 1'b0, 1'b0);
        pulse_a(16'h0100, 32'h8888_0000, 1'b1, 1'b1);
        push_exp(0, K_PEND,  0, 32'h0000_0000, "restore_pending");
        push_exp(0, K_PARAM, 7, 32'h0000_0000, "restore_slot7");
        push_exp(0, K_PARAM, 8, 32'h0000_0000, "restore_slot8");
        push_exp(0, K_PARAM, 0, 32'h3F66_6666, "restore_slot0");
        push_exp(0, K_PARAM, 2, 32'h3D14_4674, "restore_slot2");
        push_exp(0, K_CNT,   0, 32'h0000_0004, "restore_cnt_held");
        push_exp(0, K_ERR,   0, 32'h0000_0001, "restore_err_held");

        // Immediate-mode bank.
        pulse_b(12'h020, 32'h0000_0008, 1'b1);
        push_exp(1, K_PARAM, 5, 32'h0000_0008, "b_wr5_active");
        push_exp(1, K_PEND,  0, 32'h0000_0000, "b_wr5_pending");
        push_exp(1, K_CNT,   0, 32'h0000_0000, "b_tick_ignored");
        b_rd_sel = 4'd5; step();
        push_exp(1, K_RD, 0, 32'h0000_0008, "b_rd_slot5");
        b_rd_sel = 4'd12; step();
        push_exp(1, K_RD, 0, 32'h0000_0000, "b_rd_out_of_range");
        pulse_b(12'h800, 32'hCAFE_F00D, 1'b0);
        push_exp(1, K_PARAM, 11, 32'hCAFE_F00D, "b_wr11_active");
        b_rd_sel = 4'd11; step();
        push_exp(1, K_RD, 0, 32'hCAFE_F00D, "b_rd_slot11");

        // Saturation run on slot 9: every tick follows a write, restore part way through.
        pulse_a(16'h0200, 32'h1000_0000, 1'b0, 1'b0);
        for (int i = 1; i <= 1000; i++) begin
            pulse_a(16'h0200, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        end
        push_exp(0, K_CNT,   0, 32'h0000_03EC, "sat_mid_cnt");
        push_exp(0, K_PARAM, 9, 32'h1000_03E7, "sat_mid_slot9");
        pulse_a(16'h0000, 32'h0000_0000, 1'b0, 1'b1);
        push_exp(0, K_CNT,   0, 32'h0000_03EC, "sat_restore_cnt_held");
        push_exp(0, K_PARAM, 9, 32'h0000_0000, "sat_restore_slot9");
        push_exp(0, K_PARAM, 4, 32'h42A0_0000, "sat_restore_slot4");
        push_exp(0, K_PEND,  0, 32'h0000_0000, "sat_restore_pending");
        pulse_a(16'h0200, 32'h1000_0000, 1'b0, 1'b0);
        for (int i = 1; i <= 64540; i++) begin
            pulse_a(16'h0200, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
            if (i == 64530) push_exp(0, K_CNT, 0, 32'h0000_FFFE, "sat_cnt_fffe");
            if (i == 64531) push_exp(0, K_CNT, 0, 32'h0000_FFFF, "sat_cnt_ffff");
        end
        push_exp(0, K_CNT,   0, 32'h0000_FFFF, "sat_cnt_held");
        push_exp(0, K_PARAM, 9, 32'h1000_FC1B, "sat_final_slot9");
        push_exp(0, K_PEND,  0, 32'h0000_0200, "sat_final_pending");

        step(); step();
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
